// File: rtl/adc_conv_reader.sv
// CNV/BUSY conversion and SPI-style readout engine for the acquisition ADC.
// Issues a convert strobe, tracks the busy handshake with a timeout, then shifts a sample in MSB first.
module adc_conv_reader #(
  parameter int DATA_WIDTH   = 16,
  parameter int CLK_DIV      = 2,
  parameter int CNV_PULSE    = 2,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ready,
  output logic                  adc_cnv,
  input  logic                  adc_busy,
  input  logic                  adc_miso,
  output logic                  adc_sck,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  output logic                  timeout_err,
  output logic [2:0]            state_dbg
);

  // Handshake: start is accepted only on a cycle where ready=1 (IDLE); starts seen
  // while ready=0 are dropped, never queued. data_valid/timeout_err are single-cycle strobes.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CNV       = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_WAIT_FALL = 3'd3,
    S_SHIFT     = 3'd4,
    S_DONE      = 3'd5,
    S_ERR       = 3'd6
  } state_t;

  localparam int CNT_MAX = (BUSY_TIMEOUT > CNV_PULSE) ? BUSY_TIMEOUT : CNV_PULSE;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DIVW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BITW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0]   CNV_LAST = CW'(CNV_PULSE - 1);
  localparam logic [CW-1:0]   TO_LAST  = CW'(BUSY_TIMEOUT - 1);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [BITW-1:0] BIT_LAST = BITW'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DIVW-1:0]       div_q, div_d;
  logic [BITW-1:0]       bit_q, bit_d;
  logic                  sck_q, sck_d;
  logic                  cnv_q;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_meta_q, busy_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      sck_q       <= 1'b0;
      cnv_q       <= 1'b0;
      shift_q     <= '0;
      data_q      <= '0;
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sck_q       <= sck_d;
      cnv_q       <= (state_d == S_CNV);
      shift_q     <= shift_d;
      data_q      <= data_d;
      busy_meta_q <= adc_busy;
      busy_s_q    <= busy_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sck_d   = sck_q;
    shift_d = shift_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CNV;
          cnt_d   = '0;
        end
      end
      S_CNV: begin
        if (cnt_q == CNV_LAST) begin
          state_d = S_WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // A busy level already high on entry counts as the rising edge.
      S_WAIT_RISE: begin
        if (busy_s_q) begin
          state_d = S_WAIT_FALL;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_FALL: begin
        if (!busy_s_q) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          div_d   = '0;
          bit_d   = '0;
          sck_d   = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Sample miso on the edge that raises SCK; the ADC updates it after SCK falls.
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sck_q) begin
            sck_d   = 1'b1;
            shift_d = {shift_q[DATA_WIDTH-2:0], adc_miso};
          end else begin
            sck_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = S_DONE;
              data_d  = shift_q;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ready       = (state_q == S_IDLE);
  assign adc_cnv     = cnv_q;
  assign adc_sck     = sck_q;
  assign data        = data_q;
  assign data_valid  = (state_q == S_DONE);
  assign timeout_err = (state_q == S_ERR);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_adc_conv_reader.sv
// Bench for adc_conv_reader: two instances (default and fast/short-timeout parameters)
// driven by a behavioural ADC model and checked against timing rules and an expected-sample queue.
module tb_adc_conv_reader;

  localparam int DW = 16;
  localparam int CD [2] = '{2, 1};
  localparam int CP [2] = '{2, 1};
  localparam int BT [2] = '{255, 10};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst = 2'b11, start = 2'b00;
  logic [1:0] ready, cnv, sck, valid, err;
  logic [1:0] busy, busy_m = 2'b00, busy_man = 2'b00, miso = 2'b00, auto_en = 2'b00;
  logic [DW-1:0] data [2];
  logic [DW-1:0] word [2];
  logic [DW-1:0] exp_data [2];
  logic [2:0] st_dbg [2];
  int rise_dly [2];
  int hold [2];

  logic [DW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  adc_conv_reader #(.DATA_WIDTH(DW), .CLK_DIV(CD[0]), .CNV_PULSE(CP[0]), .BUSY_TIMEOUT(BT[0])) dut_a (
    .clk(clk), .rst(rst[0]), .start(start[0]), .ready(ready[0]), .adc_cnv(cnv[0]),
    .adc_busy(busy[0]), .adc_miso(miso[0]), .adc_sck(sck[0]), .data(data[0]),
    .data_valid(valid[0]), .timeout_err(err[0]), .state_dbg(st_dbg[0]));

  adc_conv_reader #(.DATA_WIDTH(DW), .CLK_DIV(CD[1]), .CNV_PULSE(CP[1]), .BUSY_TIMEOUT(BT[1])) dut_b (
    .clk(clk), .rst(rst[1]), .start(start[1]), .ready(ready[1]), .adc_cnv(cnv[1]),
    .adc_busy(busy[1]), .adc_miso(miso[1]), .adc_sck(sck[1]), .data(data[1]),
    .data_valid(valid[1]), .timeout_err(err[1]), .state_dbg(st_dbg[1]));

  // ADC model: busy rises rise_dly cycles after CNV falls, holds, then data shifts out on SCK falls.
  for (genvar g = 0; g < 2; g++) begin : g_adc
    int bit_idx = 0;
    assign busy[g] = busy_m[g] | busy_man[g];
    always begin
      @(negedge cnv[g]);
      if (auto_en[g]) begin
        repeat (rise_dly[g]) @(negedge clk);
        busy_m[g] = 1'b1;
        repeat (hold[g]) @(negedge clk);
        busy_m[g] = 1'b0;
        bit_idx = DW - 1;
        miso[g] = word[g][DW-1];
      end
    end
    always @(negedge sck[g]) begin
      if (bit_idx > 0) begin
        bit_idx = bit_idx - 1;
        miso[g] = word[g][bit_idx];
      end
    end
  end

  task automatic check(string tag, int i, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, i, obs, expv);
    end
  endtask

  // Monitor: waveform statistics sampled at the falling clock edge.
  int cyc = 0;
  int cnv_cycles [2], cnv_pulses [2], cnv_last [2];
  int sck_rises [2], first_rise [2], last_rise [2], min_gap [2], max_gap [2];
  int valid_cnt [2], t_valid [2], err_cnt [2], t_err [2];
  logic [1:0] cnv_prev = 2'b00, sck_prev = 2'b00;

  always @(negedge clk) begin
    int gap;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (cnv[i]) begin
        cnv_cycles[i]++;
        cnv_last[i] = cyc;
        if (!cnv_prev[i]) cnv_pulses[i]++;
      end
      if (sck[i] && !sck_prev[i]) begin
        if (sck_rises[i] == 0) first_rise[i] = cyc;
        else begin
          gap = cyc - last_rise[i];
          if (gap < min_gap[i]) min_gap[i] = gap;
          if (gap > max_gap[i]) max_gap[i] = gap;
        end
        last_rise[i] = cyc;
        sck_rises[i]++;
      end
      if (valid[i]) begin valid_cnt[i]++; t_valid[i] = cyc; end
      if (err[i]) begin err_cnt[i]++; t_err[i] = cyc; end
      check("valid_err_excl", i, 32'(valid[i] & err[i]), 32'd0);
      check("cnv_sck_excl", i, 32'(cnv[i] & sck[i]), 32'd0);
      cnv_prev[i] = cnv[i];
      sck_prev[i] = sck[i];
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon(int i);
    cnv_cycles[i] = 0; cnv_pulses[i] = 0; cnv_last[i] = 0;
    sck_rises[i] = 0; first_rise[i] = 0; last_rise[i] = 0;
    min_gap[i] = 1 << 30; max_gap[i] = 0;
    valid_cnt[i] = 0; t_valid[i] = 0; err_cnt[i] = 0; t_err[i] = 0;
  endtask

  task automatic conv(int i, logic [DW-1:0] w, int rd, int hd, bit stale, bit extra);
    int n = 0;
    int busy_seen = 0;
    bit s1 = 1'b0, s2 = 1'b0;
    logic [DW-1:0] got;
    word[i] = w; rise_dly[i] = rd; hold[i] = hd; auto_en[i] = 1'b1;
    exp_q.push_back(w);
    if (stale) begin
      busy_man[i] = 1'b1;
      repeat (3) step();
    end
    clear_mon(i);
    start[i] = 1'b1;
    step();
    start[i] = 1'b0;
    while (valid_cnt[i] == 0 && err_cnt[i] == 0 && n < 3000) begin
      if (busy_m[i]) busy_man[i] = 1'b0;
      start[i] = 1'b0;
      if (extra) begin
        if (busy[i]) busy_seen++;
        if (!s1 && busy_seen == 5) begin start[i] = 1'b1; s1 = 1'b1; end
        else if (!s2 && sck_rises[i] == 3) begin start[i] = 1'b1; s2 = 1'b1; end
      end
      step();
      n++;
    end
    start[i] = 1'b0;
    check("valid_seen", i, valid_cnt[i], 1);
    got = exp_q.pop_front();
    check("data", i, 32'(data[i]), 32'(got));
    exp_data[i] = got;
    check("sck_low_done", i, 32'(sck[i]), 0);
    check("shift_len", i, t_valid[i] - first_rise[i] + CD[i], 2 * CD[i] * DW);
    step();
    check("ready_after", i, 32'(ready[i]), 1);
    check("valid_once", i, valid_cnt[i], 1);
    check("no_err", i, err_cnt[i], 0);
    check("cnv_len", i, cnv_cycles[i], CP[i]);
    check("cnv_pulses", i, cnv_pulses[i], 1);
    check("sck_rises", i, sck_rises[i], DW);
    check("sck_gap_min", i, min_gap[i], 2 * CD[i]);
    check("sck_gap_max", i, max_gap[i], 2 * CD[i]);
  endtask

  task automatic conv_timeout(int i, bit stuck);
    int n = 0;
    auto_en[i] = 1'b0;
    busy_man[i] = stuck;
    repeat (3) step();
    clear_mon(i);
    start[i] = 1'b1;
    step();
    start[i] = 1'b0;
    while (valid_cnt[i] == 0 && err_cnt[i] == 0 && n < 3000) begin
      step();
      n++;
    end
    check("err_seen", i, err_cnt[i], 1);
    check("err_time", i, t_err[i] - cnv_last[i], BT[i] + 1 + int'(stuck));
    check("data_hold", i, 32'(data[i]), 32'(exp_data[i]));
    check("no_valid", i, valid_cnt[i], 0);
    check("no_sck", i, sck_rises[i], 0);
    step();
    check("ready_after_err", i, 32'(ready[i]), 1);
    check("err_once", i, err_cnt[i], 1);
    busy_man[i] = 1'b0;
    repeat (3) step();
    auto_en[i] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rise_dly = '{3, 3};
    hold = '{20, 4};
    word = '{16'h0, 16'h0};
    exp_data = '{16'h0, 16'h0};
    rst = 2'b11;
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", i, 32'(ready[i]), 1);
      check("rst_cnv", i, 32'(cnv[i]), 0);
      check("rst_sck", i, 32'(sck[i]), 0);
      check("rst_data", i, 32'(data[i]), 0);
      check("rst_valid", i, 32'(valid[i]), 0);
      check("rst_err", i, 32'(err[i]), 0);
    end
    rst = 2'b00;
    step();

    // Nominal conversion, then starts while busy, then back-to-back starts.
    conv(0, 16'hA5C3, 3, 20, 1'b0, 1'b0);
    conv(0, 16'h0001, 3, 20, 1'b0, 1'b1);
    conv(0, 16'h8000, 3, 20, 1'b0, 1'b0);
    // Busy already high when the handshake begins.
    conv(0, 16'($urandom_range(0, 16'hFFFF)), 4, 12, 1'b1, 1'b0);

    // Reset during the shift phase.
    word[0] = 16'hBEEF; rise_dly[0] = 3; hold[0] = 10; auto_en[0] = 1'b1;
    clear_mon(0);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    n = 0;
    while (sck_rises[0] < 5 && n < 3000) begin
      step();
      n++;
    end
    check("rst_reach_sck5", 0, sck_rises[0], 5);
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    check("midrst_sck", 0, 32'(sck[0]), 0);
    check("midrst_data", 0, 32'(data[0]), 0);
    check("midrst_ready", 0, 32'(ready[0]), 1);
    exp_data[0] = '0;
    repeat (100) step();
    check("midrst_no_valid", 0, valid_cnt[0], 0);
    check("midrst_no_err", 0, err_cnt[0], 0);
    check("midrst_data_hold", 0, 32'(data[0]), 0);
    conv(0, 16'h1234, 3, 20, 1'b0, 1'b0);

    // Fast instance: full conversion, then both timeout flavours.
    conv(1, 16'hFFFF, 3, 4, 1'b0, 1'b0);
    conv_timeout(1, 1'b0);
    conv_timeout(1, 1'b1);
    conv(1, 16'h5A5A, 2, 3, 1'b0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      conv(0, 16'($urandom_range(0, 16'hFFFF)), $urandom_range(1, 6), $urandom_range(1, 30), 1'b0, 1'b0);
      conv(1, 16'($urandom_range(0, 16'hFFFF)), $urandom_range(1, 4), $urandom_range(1, 5), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
